// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: funct3 encodings, the CSR
// addresses this unit knows about, and the sequencing FSM state type.
// The mscratch address is only decoded when CSR_SCRATCH_EN is defined.
package csr_pkg;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam logic [11:0] ADR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADR_TIME     = 12'hC01;
    localparam logic [11:0] ADR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADR_TIMEH    = 12'hC81;
    localparam logic [11:0] ADR_INSTRETH = 12'hC82;
    localparam logic [11:0] ADR_MHARTID  = 12'hF14;
    localparam logic [11:0] ADR_MSCRATCH = 12'h340;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_RESP
    } state_e;

    // RW forms always write; set/clear forms write only when rs1/zimm is nonzero.
    function automatic logic f3_writes(input logic [2:0] f3, input logic src_x0);
        return (f3[1:0] == 2'b01) || !src_x0;
    endfunction

endpackage

// File: rtl/csr_legal_check.sv
// Combinational legality check for a Zicsr access: valid funct3, an
// implemented address, and no write to a read-only (addr[11:10]==2'b11) CSR.
// mscratch (0x340) counts as implemented only when CSR_SCRATCH_EN is defined.
module csr_legal_check
    import csr_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [11:0] adr,
    input  logic        write_intent,
    output logic        illegal
);

    logic funct3_ok;
    logic adr_ok;

    // Decode funct3 and address, then combine with the read-only write rule.
    always_comb begin
        funct3_ok = 1'b0;
        adr_ok    = 1'b0;
        case (funct3)
            F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI: funct3_ok = 1'b1;
            default:                                     funct3_ok = 1'b0;
        endcase
        case (adr)
            ADR_CYCLE, ADR_TIME, ADR_INSTRET,
            ADR_CYCLEH, ADR_TIMEH, ADR_INSTRETH,
            ADR_MHARTID:  adr_ok = 1'b1;
`ifdef CSR_SCRATCH_EN
            ADR_MSCRATCH: adr_ok = 1'b1;
`endif
            default:      adr_ok = 1'b0;
        endcase
        illegal = !funct3_ok || !adr_ok || (write_intent && (adr[11:10] == 2'b11));
    end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr execution unit: accepts a CSR instruction, drives the address to the
// counter/ID CSR block, samples the old value one cycle later, applies
// legality and read-modify-write, and holds the rd result until accepted.
// Optional feature: define CSR_SCRATCH_EN to add a writable mscratch at 0x340.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] SCRATCH_RESET = 32'd0
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic [11:0] REQ_ADR,
    input  logic [31:0] REQ_SRC,
    input  logic        REQ_SRC_X0,
    output logic [11:0] CSR_ADR,
    input  logic [31:0] CSR_IN,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ILLEGAL
);

    state_e      state_q, state_d;
    logic [11:0] csr_adr_q, csr_adr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] src_q, src_d;
    logic        src_x0_q, src_x0_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic [31:0] old_value;
    logic        write_intent;
    logic        illegal;

`ifdef CSR_SCRATCH_EN
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] new_value;
`else
    logic        unused_cfg;
    assign unused_cfg = ^{SCRATCH_RESET, src_q};
`endif

    assign write_intent = f3_writes(funct3_q, src_x0_q);

    csr_legal_check u_legal (
        .funct3       (funct3_q),
        .adr          (csr_adr_q),
        .write_intent (write_intent),
        .illegal      (illegal)
    );

    // Select the old CSR value and, with mscratch present, its modified value.
    always_comb begin
        old_value = CSR_IN;
`ifdef CSR_SCRATCH_EN
        if (csr_adr_q == ADR_MSCRATCH) begin
            old_value = mscratch_q;
        end
        case (funct3_q[1:0])
            2'b01:   new_value = src_q;
            2'b10:   new_value = old_value | src_q;
            default: new_value = old_value & ~src_q;
        endcase
`endif
    end

    // Next-state and datapath update for the IDLE -> READ -> RESP sequence.
    always_comb begin
        state_d       = state_q;
        csr_adr_d     = csr_adr_q;
        funct3_d      = funct3_q;
        src_d         = src_q;
        src_x0_d      = src_x0_q;
        rsp_data_d    = rsp_data_q;
        rsp_illegal_d = rsp_illegal_q;
`ifdef CSR_SCRATCH_EN
        mscratch_d    = mscratch_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    csr_adr_d = REQ_ADR;
                    funct3_d  = REQ_FUNCT3;
                    src_d     = REQ_SRC;
                    src_x0_d  = REQ_SRC_X0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                rsp_illegal_d = illegal;
                rsp_data_d    = illegal ? 32'd0 : old_value;
`ifdef CSR_SCRATCH_EN
                if (!illegal && write_intent && (csr_adr_q == ADR_MSCRATCH)) begin
                    mscratch_d = new_value;
                end
`endif
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q       <= ST_IDLE;
            csr_adr_q     <= 12'd0;
            funct3_q      <= 3'd0;
            src_q         <= 32'd0;
            src_x0_q      <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_illegal_q <= 1'b0;
`ifdef CSR_SCRATCH_EN
            mscratch_q    <= SCRATCH_RESET;
`endif
        end else begin
            state_q       <= state_d;
            csr_adr_q     <= csr_adr_d;
            funct3_q      <= funct3_d;
            src_q         <= src_d;
            src_x0_q      <= src_x0_d;
            rsp_data_q    <= rsp_data_d;
            rsp_illegal_q <= rsp_illegal_d;
`ifdef CSR_SCRATCH_EN
            mscratch_q    <= mscratch_d;
`endif
        end
    end

    assign REQ_READY   = (state_q == ST_IDLE);
    assign RSP_VALID   = (state_q == ST_RESP);
    assign CSR_ADR     = csr_adr_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_ILLEGAL = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed cases plus randomized CSR accesses
// checked against an instruction-level model of Zicsr behaviour.
// Works with or without CSR_SCRATCH_EN defined.
module tb_csr_access_unit;

    localparam logic [31:0] SCR_RESET = 32'h1357_9BDF;
`ifdef CSR_SCRATCH_EN
    localparam bit SCRATCH_ON = 1'b1;
`else
    localparam bit SCRATCH_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [2:0]  REQ_FUNCT3 = 3'd0;
    logic [11:0] REQ_ADR = 12'd0;
    logic [31:0] REQ_SRC = 32'd0;
    logic        REQ_SRC_X0 = 1'b0;
    logic [11:0] CSR_ADR;
    logic [31:0] CSR_IN = 32'd0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [31:0] RSP_DATA;
    logic        RSP_ILLEGAL;

    int          totalCount = 0;
    int          badCount = 0;
    logic [31:0] scratchModel = SCR_RESET;

    csr_access_unit #(.SCRATCH_RESET(SCR_RESET)) dut (
        .CLK         (CLK),
        .RES_N       (RES_N),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .REQ_FUNCT3  (REQ_FUNCT3),
        .REQ_ADR     (REQ_ADR),
        .REQ_SRC     (REQ_SRC),
        .REQ_SRC_X0  (REQ_SRC_X0),
        .CSR_ADR     (CSR_ADR),
        .CSR_IN      (CSR_IN),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_DATA    (RSP_DATA),
        .RSP_ILLEGAL (RSP_ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h want %h", tag, actual, expected);
        end
    endtask

    // Instruction-level Zicsr model: returns rd result and updates mscratch.
    task automatic modelCsr(input logic [2:0] f3, input logic [11:0] adr, input logic [31:0] src,
                            input logic x0, input logic [31:0] csrVal,
                            output logic [31:0] data, output logic ill);
        bit          writes;
        bit          f3Ok;
        bit          known;
        logic [31:0] old;
        writes = (f3 == 3'd1) || (f3 == 3'd5) || !x0;
        f3Ok   = f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        known  = (adr inside {12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82, 12'hF14})
                 || (SCRATCH_ON && adr == 12'h340);
        old    = (adr == 12'h340) ? scratchModel : csrVal;
        ill    = !f3Ok || !known || (writes && adr >= 12'hC00);
        data   = ill ? 32'd0 : old;
        if (!ill && writes && adr == 12'h340) begin
            if (f3 == 3'd1 || f3 == 3'd5)      scratchModel = src;
            else if (f3 == 3'd2 || f3 == 3'd6) scratchModel = old | src;
            else                               scratchModel = old & ~src;
        end
    endtask

    // One full transaction with junk requests presented while busy.
    task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] adr, input logic [31:0] src,
                                 input logic x0, input logic [31:0] csrVal, input int hold);
        logic [31:0] expData;
        logic        expIll;
        @(negedge CLK);
        checkOutput("req_ready_idle", 32'(REQ_READY), 32'd1);
        REQ_VALID  = 1'b1;
        REQ_FUNCT3 = f3;
        REQ_ADR    = adr;
        REQ_SRC    = src;
        REQ_SRC_X0 = x0;
        @(posedge CLK); #1;
        REQ_ADR    = adr ^ 12'h0A5;
        REQ_FUNCT3 = 3'($urandom_range(0, 7));
        REQ_SRC    = $urandom;
        checkOutput("csr_adr_read", 32'(CSR_ADR), 32'(adr));
        checkOutput("req_ready_read", 32'(REQ_READY), 32'd0);
        checkOutput("rsp_valid_read", 32'(RSP_VALID), 32'd0);
        CSR_IN = csrVal;
        modelCsr(f3, adr, src, x0, csrVal, expData, expIll);
        @(posedge CLK); #1;
        CSR_IN = $urandom;
        for (int h = 0; h <= hold; h++) begin
            checkOutput("rsp_valid", 32'(RSP_VALID), 32'd1);
            checkOutput("rsp_data", RSP_DATA, expData);
            checkOutput("rsp_illegal", 32'(RSP_ILLEGAL), 32'(expIll));
            checkOutput("req_ready_resp", 32'(REQ_READY), 32'd0);
            checkOutput("csr_adr_resp", 32'(CSR_ADR), 32'(adr));
            if (h == hold) RSP_READY = 1'b1;
            @(posedge CLK); #1;
        end
        RSP_READY = 1'b0;
        REQ_VALID = 1'b0;
        checkOutput("rsp_valid_done", 32'(RSP_VALID), 32'd0);
        checkOutput("req_ready_done", 32'(REQ_READY), 32'd1);
        checkOutput("csr_adr_hold", 32'(CSR_ADR), 32'(adr));
    endtask

    initial begin
        logic [11:0] adrPool [10];
        logic [2:0]  f3;
        logic [11:0] adr;
        logic        x0;
        logic [31:0] src;

        adrPool = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82,
                    12'hF14, 12'h340, 12'hC03, 12'h341};

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_req_ready", 32'(REQ_READY), 32'd1);
        checkOutput("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
        checkOutput("reset_rsp_data", RSP_DATA, 32'd0);
        checkOutput("reset_rsp_illegal", 32'(RSP_ILLEGAL), 32'd0);
        checkOutput("reset_csr_adr", 32'(CSR_ADR), 32'd0);
        @(negedge CLK);
        RES_N = 1'b1;

        applyStimulus(3'b010, 12'hC00, 32'd0, 1'b1, 32'h0000_1234, 0);
        applyStimulus(3'b001, 12'hC01, 32'd5, 1'b0, $urandom, 0);
        applyStimulus(3'b001, 12'h340, 32'hA5A5_A5A5, 1'b0, $urandom, 0);
        applyStimulus(3'b011, 12'h340, 32'h0000_FFFF, 1'b0, $urandom, 1);
        applyStimulus(3'b010, 12'h340, 32'd0, 1'b1, $urandom, 0);
        applyStimulus(3'b100, 12'hF14, 32'd0, 1'b1, 32'd3, 0);
        applyStimulus(3'b010, 12'hF14, 32'd0, 1'b1, 32'd3, 0);
        applyStimulus(3'b000, 12'hC00, 32'd0, 1'b1, $urandom, 0);
        applyStimulus(3'b010, 12'hC02, 32'd0, 1'b1, $urandom, 5);
        applyStimulus(3'b010, 12'hC80, 32'd1, 1'b0, $urandom, 0);
        applyStimulus(3'b111, 12'hC81, 32'd0, 1'b1, $urandom, 0);
        applyStimulus(3'b101, 12'hC82, 32'd0, 1'b1, $urandom, 0);

        for (int n = 0; n < 150; n++) begin
            f3  = 3'($urandom_range(0, 7));
            adr = adrPool[$urandom_range(0, 9)];
            x0  = 1'($urandom_range(0, 1));
            if (x0)         src = 32'd0;
            else if (f3[2]) src = 32'($urandom_range(1, 31));
            else            src = $urandom | 32'd1;
            applyStimulus(f3, adr, src, x0, $urandom, int'($urandom_range(0, 3)));
        end

        // Reset during READ: in-flight request dropped, mscratch back to reset value.
        @(negedge CLK);
        REQ_VALID  = 1'b1;
        REQ_FUNCT3 = 3'b001;
        REQ_ADR    = 12'h340;
        REQ_SRC    = 32'hDEAD_BEEF;
        REQ_SRC_X0 = 1'b0;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        RES_N = 1'b0;
        #1;
        checkOutput("midreset_req_ready", 32'(REQ_READY), 32'd1);
        checkOutput("midreset_rsp_valid", 32'(RSP_VALID), 32'd0);
        checkOutput("midreset_rsp_data", RSP_DATA, 32'd0);
        checkOutput("midreset_rsp_illegal", 32'(RSP_ILLEGAL), 32'd0);
        checkOutput("midreset_csr_adr", 32'(CSR_ADR), 32'd0);
        scratchModel = SCR_RESET;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RES_N = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
            checkOutput("postreset_no_rsp", 32'(RSP_VALID), 32'd0);
        end
        applyStimulus(3'b010, 12'h340, 32'd0, 1'b1, $urandom, 0);
        applyStimulus(3'b010, 12'hC00, 32'd0, 1'b1, 32'h0BAD_F00D, 2);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
